// File: rtl/gtf_link_supervisor_if.sv
// Signal bundle between the GTF link supervisor (slave) and the GT wizard / status logic (master).
interface gtf_link_supervisor_if #(
  parameter int NUM_CHANNEL = 1
) ();
  logic                       gtf_clk_wiz_locked;
  logic [NUM_CHANNEL-1:0]     link_status_in;
  logic [NUM_CHANNEL-1:0]     link_down_latched_clr;
  logic [NUM_CHANNEL-1:0]     ch_retry_clr;
  logic [NUM_CHANNEL-1:0]     ch_reset_out;
  logic [NUM_CHANNEL-1:0]     link_stable;
  logic [NUM_CHANNEL-1:0]     link_down_latched;
  logic [8*NUM_CHANNEL-1:0]   link_loss_cnt;
  logic [NUM_CHANNEL-1:0]     retry_exhausted;
  logic                       global_busy;

  modport master (
    output gtf_clk_wiz_locked, link_status_in, link_down_latched_clr, ch_retry_clr,
    input  ch_reset_out, link_stable, link_down_latched, link_loss_cnt, retry_exhausted, global_busy
  );

  modport slave (
    input  gtf_clk_wiz_locked, link_status_in, link_down_latched_clr, ch_retry_clr,
    output ch_reset_out, link_stable, link_down_latched, link_loss_cnt, retry_exhausted, global_busy
  );
endinterface

// File: rtl/gtf_link_supervisor.sv
// Power-up sequencer plus per-channel GT reset / link qualification FSMs.
// Build option GTF_LINK_AUTO_RESET_EN adds a link timeout, automatic retries and a FAIL state.
module gtf_link_supervisor #(
  parameter int NUM_CHANNEL   = 1,
  parameter int POWERUP_DELAY = 100,
  parameter int RESET_CYCLES  = 16,
  parameter int STABLE_CYCLES = 2048,
  parameter int LINK_TIMEOUT  = 1000000,
  parameter int MAX_RETRIES   = 4
) (
  input logic                  freerun_clk,
  input logic                  hb_gtwiz_reset_all_in,
  gtf_link_supervisor_if.slave sup
);

  localparam int PW = $clog2(POWERUP_DELAY + 1);
  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int QW = $clog2(STABLE_CYCLES);
  localparam logic [PW-1:0] PWR_LOAD  = PW'(POWERUP_DELAY);
  localparam logic [RW-1:0] RST_LAST  = RW'(RESET_CYCLES - 1);
  localparam logic [QW-1:0] QUAL_LAST = QW'(STABLE_CYCLES - 1);

  if (NUM_CHANNEL < 1 || POWERUP_DELAY < 1 || RESET_CYCLES < 1 || STABLE_CYCLES < 2 ||
      LINK_TIMEOUT < 2 || MAX_RETRIES < 1) begin : g_param_check
    $error("gtf_link_supervisor: parameter out of range");
  end

  typedef enum logic [2:0] {
    CH_RST    = 3'd0,
    WAIT_LINK = 3'd1,
    QUALIFY   = 3'd2,
    STABLE    = 3'd3,
    FAIL      = 3'd4
  } ch_state_e;

  logic                     locked_meta_q, locked_meta_d, locked_sync_q, locked_sync_d;
  logic [NUM_CHANNEL-1:0]   link_meta_q, link_meta_d, link_sync_q, link_sync_d;
  logic [PW-1:0]            pwr_timer_q, pwr_timer_d;
  logic                     global_busy_q, global_busy_d;
  ch_state_e                state_q [NUM_CHANNEL];
  ch_state_e                state_d [NUM_CHANNEL];
  logic [RW-1:0]            rst_cnt_q [NUM_CHANNEL];
  logic [RW-1:0]            rst_cnt_d [NUM_CHANNEL];
  logic [QW-1:0]            qual_cnt_q [NUM_CHANNEL];
  logic [QW-1:0]            qual_cnt_d [NUM_CHANNEL];
  logic [NUM_CHANNEL-1:0]   loss_s;
  logic [NUM_CHANNEL-1:0]   ch_reset_q, ch_reset_d, link_stable_q, link_stable_d;
  logic [NUM_CHANNEL-1:0]   latched_q, latched_d;
  logic [8*NUM_CHANNEL-1:0] loss_cnt_q, loss_cnt_d;
`ifdef GTF_LINK_AUTO_RESET_EN
  localparam int TW = $clog2(LINK_TIMEOUT);
  localparam int YW = $clog2(MAX_RETRIES + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(LINK_TIMEOUT - 1);
  localparam logic [YW-1:0] RETRY_LAST = YW'(MAX_RETRIES - 1);
  logic [TW-1:0]            tmo_cnt_q [NUM_CHANNEL];
  logic [TW-1:0]            tmo_cnt_d [NUM_CHANNEL];
  logic [YW-1:0]            retry_q [NUM_CHANNEL];
  logic [YW-1:0]            retry_d [NUM_CHANNEL];
  logic [NUM_CHANNEL-1:0]   retry_exh_q, retry_exh_d;
`endif

  // Next-state logic: synchronisers, power-up timer, channel FSMs and loss bookkeeping.
  always_comb begin
    locked_meta_d = sup.gtf_clk_wiz_locked;
    locked_sync_d = locked_meta_q;
    link_meta_d   = sup.link_status_in;
    link_sync_d   = link_meta_q;
    if (!locked_sync_q) begin
      pwr_timer_d = PWR_LOAD;
    end else if (pwr_timer_q != '0) begin
      pwr_timer_d = pwr_timer_q - PW'(1);
    end else begin
      pwr_timer_d = pwr_timer_q;
    end
    // Channels obey the busy value being registered so they and global_busy move together.
    global_busy_d = !locked_sync_q || (pwr_timer_q != '0);
    loss_s        = '0;
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    qual_cnt_d    = qual_cnt_q;
    ch_reset_d    = '0;
    link_stable_d = '0;
    latched_d     = latched_q;
    loss_cnt_d    = loss_cnt_q;
`ifdef GTF_LINK_AUTO_RESET_EN
    tmo_cnt_d     = tmo_cnt_q;
    retry_d       = retry_q;
    retry_exh_d   = '0;
`endif
    for (int i = 0; i < NUM_CHANNEL; i++) begin
      if (global_busy_d) begin
        state_d[i]    = CH_RST;
        rst_cnt_d[i]  = '0;
        qual_cnt_d[i] = '0;
`ifdef GTF_LINK_AUTO_RESET_EN
        tmo_cnt_d[i]  = '0;
        retry_d[i]    = '0;
`endif
      end else begin
        case (state_q[i])
          CH_RST: begin
            if (rst_cnt_q[i] == RST_LAST) begin
              state_d[i]   = WAIT_LINK;
              rst_cnt_d[i] = '0;
            end else begin
              rst_cnt_d[i] = rst_cnt_q[i] + RW'(1);
            end
          end
          WAIT_LINK: begin
            if (link_sync_q[i]) begin
              state_d[i]    = QUALIFY;
              qual_cnt_d[i] = QW'(1);
`ifdef GTF_LINK_AUTO_RESET_EN
              tmo_cnt_d[i]  = '0;
            end else if (tmo_cnt_q[i] == TMO_LAST) begin
              tmo_cnt_d[i]  = '0;
              retry_d[i]    = retry_q[i] + YW'(1);
              state_d[i]    = (retry_q[i] == RETRY_LAST) ? FAIL : CH_RST;
            end else begin
              tmo_cnt_d[i]  = tmo_cnt_q[i] + TW'(1);
            end
`else
            end else begin
              state_d[i]    = WAIT_LINK;
            end
`endif
          end
          QUALIFY: begin
            if (!link_sync_q[i]) begin
              state_d[i]    = WAIT_LINK;
              qual_cnt_d[i] = '0;
            end else if (qual_cnt_q[i] == QUAL_LAST) begin
              state_d[i]    = STABLE;
              qual_cnt_d[i] = '0;
`ifdef GTF_LINK_AUTO_RESET_EN
              retry_d[i]    = '0;
`endif
            end else begin
              qual_cnt_d[i] = qual_cnt_q[i] + QW'(1);
            end
          end
          STABLE: begin
            if (!link_sync_q[i]) begin
              loss_s[i]  = 1'b1;
`ifdef GTF_LINK_AUTO_RESET_EN
              retry_d[i] = retry_q[i] + YW'(1);
              state_d[i] = (retry_q[i] == RETRY_LAST) ? FAIL : CH_RST;
`else
              state_d[i] = WAIT_LINK;
`endif
            end else begin
              state_d[i] = STABLE;
            end
          end
`ifdef GTF_LINK_AUTO_RESET_EN
          FAIL: begin
            if (sup.ch_retry_clr[i]) begin
              state_d[i] = CH_RST;
              retry_d[i] = '0;
            end else begin
              state_d[i] = FAIL;
            end
          end
`endif
          default: state_d[i] = CH_RST;
        endcase
      end
      ch_reset_d[i]    = (state_d[i] == CH_RST);
      link_stable_d[i] = (state_d[i] == STABLE);
`ifdef GTF_LINK_AUTO_RESET_EN
      retry_exh_d[i]   = (state_d[i] == FAIL);
`endif
      // A loss in the same cycle as a clear wins: latch stays set and the count restarts at 1.
      if (loss_s[i]) begin
        latched_d[i] = 1'b1;
        if (sup.link_down_latched_clr[i]) begin
          loss_cnt_d[8*i +: 8] = 8'd1;
        end else if (loss_cnt_q[8*i +: 8] == 8'hFF) begin
          loss_cnt_d[8*i +: 8] = 8'hFF;
        end else begin
          loss_cnt_d[8*i +: 8] = loss_cnt_q[8*i +: 8] + 8'd1;
        end
      end else if (sup.link_down_latched_clr[i]) begin
        latched_d[i]         = 1'b0;
        loss_cnt_d[8*i +: 8] = 8'd0;
      end else begin
        latched_d[i]         = latched_q[i];
        loss_cnt_d[8*i +: 8] = loss_cnt_q[8*i +: 8];
      end
    end
  end

  // State and output registers.
  always_ff @(posedge freerun_clk or posedge hb_gtwiz_reset_all_in) begin
    if (hb_gtwiz_reset_all_in) begin
      locked_meta_q <= 1'b0;
      locked_sync_q <= 1'b0;
      link_meta_q   <= '0;
      link_sync_q   <= '0;
      pwr_timer_q   <= PWR_LOAD;
      global_busy_q <= 1'b1;
      ch_reset_q    <= '1;
      link_stable_q <= '0;
      latched_q     <= '0;
      loss_cnt_q    <= '0;
      for (int i = 0; i < NUM_CHANNEL; i++) begin
        state_q[i]    <= CH_RST;
        rst_cnt_q[i]  <= '0;
        qual_cnt_q[i] <= '0;
`ifdef GTF_LINK_AUTO_RESET_EN
        tmo_cnt_q[i]  <= '0;
        retry_q[i]    <= '0;
`endif
      end
`ifdef GTF_LINK_AUTO_RESET_EN
      retry_exh_q   <= '0;
`endif
    end else begin
      locked_meta_q <= locked_meta_d;
      locked_sync_q <= locked_sync_d;
      link_meta_q   <= link_meta_d;
      link_sync_q   <= link_sync_d;
      pwr_timer_q   <= pwr_timer_d;
      global_busy_q <= global_busy_d;
      ch_reset_q    <= ch_reset_d;
      link_stable_q <= link_stable_d;
      latched_q     <= latched_d;
      loss_cnt_q    <= loss_cnt_d;
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      qual_cnt_q    <= qual_cnt_d;
`ifdef GTF_LINK_AUTO_RESET_EN
      tmo_cnt_q     <= tmo_cnt_d;
      retry_q       <= retry_d;
      retry_exh_q   <= retry_exh_d;
`endif
    end
  end

  assign sup.global_busy       = global_busy_q;
  assign sup.ch_reset_out      = ch_reset_q;
  assign sup.link_stable       = link_stable_q;
  assign sup.link_down_latched = latched_q;
  assign sup.link_loss_cnt     = loss_cnt_q;
`ifdef GTF_LINK_AUTO_RESET_EN
  assign sup.retry_exhausted   = retry_exh_q;
`else
  logic retry_clr_unused_s;
  assign retry_clr_unused_s    = ^sup.ch_retry_clr;
  assign sup.retry_exhausted   = '0;
`endif

endmodule

// File: tb/tb_gtf_link_supervisor.sv
// Scoreboard bench for gtf_link_supervisor: stimulus queues timed expectations, a monitor checks them.
module tb_gtf_link_supervisor;
  localparam int NCH = 2;
  localparam int PD  = 10;
  localparam int RC  = 4;
  localparam int SC  = 16;
  localparam int LT  = 64;
  localparam int MR  = 3;

  localparam int S_BUSY = 0, S_CHRST = 1, S_STABLE = 2, S_LATCH = 3, S_LOSS = 4, S_RETRY = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gtf_link_supervisor_if #(.NUM_CHANNEL(NCH)) sup_if ();

  gtf_link_supervisor #(
    .NUM_CHANNEL(NCH), .POWERUP_DELAY(PD), .RESET_CYCLES(RC),
    .STABLE_CYCLES(SC), .LINK_TIMEOUT(LT), .MAX_RETRIES(MR)
  ) dut (
    .freerun_clk(clk),
    .hb_gtwiz_reset_all_in(rst),
    .sup(sup_if.slave)
  );

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] want;
    string       nm;
  } exp_t;

  exp_t sb_q[$];
  int   cyc     = 0;
  int   n_check = 0;
  int   n_pass  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int at, input int sig, input logic [31:0] want, input string nm);
    exp_t e;
    int   pos;
    e.cyc  = at;
    e.sig  = sig;
    e.want = want;
    e.nm   = nm;
    pos = sb_q.size();
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc > at) pos = i;
    end
    sb_q.insert(pos, e);
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      S_BUSY:   observe = {31'd0, sup_if.global_busy};
      S_CHRST:  observe = {30'd0, sup_if.ch_reset_out};
      S_STABLE: observe = {30'd0, sup_if.link_stable};
      S_LATCH:  observe = {30'd0, sup_if.link_down_latched};
      S_LOSS:   observe = {16'd0, sup_if.link_loss_cnt};
      S_RETRY:  observe = {30'd0, sup_if.retry_exhausted};
      default:  observe = 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: outputs are stable at the falling edge; compare every expectation due this cycle.
  initial begin : monitor
    exp_t        e;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e   = sb_q.pop_front();
        got = observe(e.sig);
        n_check++;
        if (e.cyc != cyc)
          $display("FAIL %s: check due at cycle %0d reached only at %0d", e.nm, e.cyc, cyc);
        else if (got !== e.want)
          $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", e.nm, cyc, got, e.want);
        else
          n_pass++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks pending", sb_q.size());
    n_check = n_check + sb_q.size() + 1;
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

  initial begin : stimulus
    int k;
    int c;
    sup_if.gtf_clk_wiz_locked    = 1'b0;
    sup_if.link_status_in        = '0;
    sup_if.link_down_latched_clr = '0;
    sup_if.ch_retry_clr          = '0;
    step(2);
    expect_at(cyc + 1, S_BUSY,   32'd1, "rst_busy");
    expect_at(cyc + 1, S_CHRST,  32'd3, "rst_chrst");
    expect_at(cyc + 1, S_STABLE, 32'd0, "rst_stable");
    expect_at(cyc + 1, S_LATCH,  32'd0, "rst_latched");
    expect_at(cyc + 1, S_LOSS,   32'd0, "rst_losscnt");
    expect_at(cyc + 1, S_RETRY,  32'd0, "rst_retry");
    step(2);
    rst = 1'b0;
    step(3);

    // Power-up: busy ends 2+PD+1 (+/-1) cycles after lock, then a RESET_CYCLES channel pulse.
    k = cyc;
    sup_if.gtf_clk_wiz_locked = 1'b1;
    expect_at(k + 11, S_BUSY,  32'd1, "pwr_busy_hold");
    expect_at(k + 14, S_BUSY,  32'd0, "pwr_busy_fall");
    expect_at(k + 14, S_CHRST, 32'd3, "pwr_chrst_hold");
    expect_at(k + 18, S_CHRST, 32'd0, "pwr_chrst_fall");

`ifdef GTF_LINK_AUTO_RESET_EN
    // Link never comes up: two retry pulses 68 cycles apart, third timeout lands in FAIL.
    expect_at(k + 79,  S_CHRST, 32'd0, "retry1_pre");
    expect_at(k + 80,  S_CHRST, 32'd3, "retry1_rise");
    expect_at(k + 83,  S_CHRST, 32'd3, "retry1_hold");
    expect_at(k + 84,  S_CHRST, 32'd0, "retry1_fall");
    expect_at(k + 147, S_CHRST, 32'd0, "retry2_pre");
    expect_at(k + 148, S_CHRST, 32'd3, "retry2_rise");
    expect_at(k + 152, S_CHRST, 32'd0, "retry2_fall");
    expect_at(k + 215, S_RETRY, 32'd0, "fail_pre");
    expect_at(k + 216, S_RETRY, 32'd3, "fail_enter");
    expect_at(k + 216, S_CHRST, 32'd0, "fail_chrst_low");
    step(k + 220 - cyc);
    c = cyc;
    sup_if.ch_retry_clr[0] = 1'b1;
    expect_at(c + 1, S_CHRST, 32'd1, "retryclr_chrst");
    expect_at(c + 1, S_RETRY, 32'd2, "retryclr_exh");
    expect_at(c + 5, S_CHRST, 32'd0, "retryclr_release");
    step(1);
    sup_if.ch_retry_clr[0] = 1'b0;
    step(8);
`else
    step(k + 22 - cyc);

    // Steady link on channel 0: stable exactly 2+SC cycles after the drive.
    k = cyc;
    sup_if.link_status_in[0] = 1'b1;
    expect_at(k + 17, S_STABLE, 32'd0, "qual_not_yet");
    expect_at(k + 18, S_STABLE, 32'd1, "qual_stable");
    expect_at(k + 18, S_CHRST,  32'd0, "qual_ch1_chrst");
    expect_at(k + 18, S_LATCH,  32'd0, "qual_latched");
    step(20);

    // First loss from STABLE.
    k = cyc;
    sup_if.link_status_in[0] = 1'b0;
    expect_at(k + 2, S_STABLE, 32'd1, "loss_stable_hold");
    expect_at(k + 2, S_LATCH,  32'd0, "loss_latch_pre");
    expect_at(k + 3, S_STABLE, 32'd0, "loss_stable_drop");
    expect_at(k + 3, S_LATCH,  32'd1, "loss_latch_set");
    expect_at(k + 3, S_LOSS,   32'h0001, "loss_cnt_one");
    step(5);

    // One-cycle glitch at qualify count 10 restarts qualification from the recovery.
    k = cyc;
    sup_if.link_status_in[0] = 1'b1;
    expect_at(k + 18, S_STABLE, 32'd0, "glitch_no_early");
    expect_at(k + 28, S_STABLE, 32'd0, "glitch_requal");
    expect_at(k + 29, S_STABLE, 32'd1, "glitch_stable");
    step(10);
    sup_if.link_status_in[0] = 1'b0;
    step(1);
    sup_if.link_status_in[0] = 1'b1;
    step(20);

    // Clear pulse.
    c = cyc;
    sup_if.link_down_latched_clr[0] = 1'b1;
    expect_at(c + 1, S_LATCH, 32'd0, "clr_latch");
    expect_at(c + 1, S_LOSS,  32'd0, "clr_cnt");
    step(1);
    sup_if.link_down_latched_clr[0] = 1'b0;
    step(2);

    // 300 losses: counter saturates at 255.
    for (int n = 0; n < 300; n++) begin
      sup_if.link_status_in[0] = 1'b0;
      step(1);
      sup_if.link_status_in[0] = 1'b1;
      step(21);
      if (n == 253) expect_at(cyc + 1, S_LOSS, 32'h00FE, "sat_254");
    end
    expect_at(cyc + 1, S_LOSS,   32'h00FF, "sat_255");
    expect_at(cyc + 1, S_LATCH,  32'd1,    "sat_latched");
    expect_at(cyc + 1, S_STABLE, 32'd1,    "sat_stable");
    step(2);

    // Clear in the same cycle as a loss: the set wins and the count restarts at 1.
    k = cyc;
    sup_if.link_status_in[0] = 1'b0;
    expect_at(k + 3, S_LATCH, 32'd1,    "clrloss_latch");
    expect_at(k + 3, S_LOSS,  32'h0001, "clrloss_cnt");
    expect_at(k + 4, S_LATCH, 32'd1,    "clrloss_latch_after");
    step(2);
    sup_if.link_down_latched_clr[0] = 1'b1;
    step(1);
    sup_if.link_down_latched_clr[0] = 1'b0;
    sup_if.link_status_in           = 2'b11;
    step(22);
    expect_at(cyc + 1, S_STABLE, 32'd3, "both_stable");
    step(2);

    // Lock loss with both channels stable: forced back to reset, loss counters untouched.
    k = cyc;
    sup_if.gtf_clk_wiz_locked = 1'b0;
    expect_at(k + 3, S_CHRST,  32'd3,    "unlock_chrst");
    expect_at(k + 3, S_STABLE, 32'd0,    "unlock_stable");
    expect_at(k + 3, S_LOSS,   32'h0001, "unlock_losscnt");
    expect_at(k + 6, S_LOSS,   32'h0001, "unlock_losscnt_hold");
    expect_at(k + 6, S_LATCH,  32'd1,    "unlock_latched");
    expect_at(k + 6, S_BUSY,   32'd1,    "unlock_busy");
    expect_at(k + 6, S_RETRY,  32'd0,    "retry_tied_low");
    step(10);
`endif

    for (int w = 0; w < 50 && sb_q.size() > 0; w++) step(1);
    if (sb_q.size() > 0) begin
      $display("FAIL scoreboard_drain: %0d checks still pending, expected 0", sb_q.size());
      n_check = n_check + sb_q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end
endmodule

// File: doc/gtf_link_supervisor.md
Name: gtf_link_supervisor

Overview:
Per-channel reset sequencer and link-stability supervisor for the GTF example top. It replaces the single power-up timer and fixed 2048-cycle link monitor with a parametrised multi-channel block. Each channel gets its own reset pulse, link qualification window, link-loss latch and counter. With the optional feature compiled in, a channel that times out or loses link is automatically retried. The block sits between the clock-wizard lock and the gtfwizard hb_gtwiz_reset_all_in / link_status_out signals.

Parameters:
NUM_CHANNEL, 1, number of GTF channels supervised
POWERUP_DELAY, 100, freerun_clk cycles after lock before any channel leaves reset
RESET_CYCLES, 16, minimum per-channel reset pulse width in cycles
STABLE_CYCLES, 2048, consecutive link-up samples required to declare link stable
LINK_TIMEOUT, 1000000, cycles in WAIT_LINK before a retry (auto-reset build only)
MAX_RETRIES, 4, retries before a channel enters FAIL (auto-reset build only)

Ports:
freerun_clk  in  1  free-running supervisor clock
hb_gtwiz_reset_all_in  in  1  asynchronous, active-high reset of all state
gtf_clk_wiz_locked  in  1  clock wizard lock; asynchronous, synchronised internally
link_status_in  in  NUM_CHANNEL  per-channel link status; asynchronous, synchronised internally
link_down_latched_clr  in  NUM_CHANNEL  single-cycle pulse; clears the loss latch and loss counter
ch_retry_clr  in  NUM_CHANNEL  single-cycle pulse; takes the channel out of FAIL
ch_reset_out  out  NUM_CHANNEL  active-high per-channel GT reset
link_stable  out  NUM_CHANNEL  channel is in STABLE
link_down_latched  out  NUM_CHANNEL  sticky flag; set on loss of a stable link
link_loss_cnt  out  8*NUM_CHANNEL  per-channel saturating loss counter, channel i at [8i+7:8i]
retry_exhausted  out  NUM_CHANNEL  channel is in FAIL
global_busy  out  1  power-up sequencing in progress

Behaviour:
- Reset is asynchronous and active-high on hb_gtwiz_reset_all_in.
  - Reset values: ch_reset_out all 1; global_busy 1; all other outputs 0; powerup timer = POWERUP_DELAY; every channel FSM in CH_RST.
- Synchronisers: gtf_clk_wiz_locked and each link_status_in bit pass through 2 flops, reset value 0. Input-to-internal latency is 2 cycles.
- Powerup timer:
  - Reloads POWERUP_DELAY while locked_sync = 0.
  - Otherwise decrements and holds at 0.
  - global_busy = !locked_sync || timer != 0, registered.
- global_busy = 1 has highest priority. It forces every channel to CH_RST with its reset counter cleared, from any state including FAIL; the retry count is cleared.
- Per-channel FSM:
  - CH_RST: ch_reset_out = 1. The reset counter counts up to RESET_CYCLES-1. Exit to WAIT_LINK when the count is done and global_busy = 0. ch_reset_out falls on the first WAIT_LINK cycle.
  - WAIT_LINK: the timeout counter increments each cycle.
    - link_sync = 1 → QUALIFY, with the qualify counter set to 1.
  - QUALIFY:
    - link_sync = 0 → WAIT_LINK; qualify and timeout counters cleared.
    - link_sync = 1 with count == STABLE_CYCLES-1 → STABLE. link_stable rises exactly STABLE_CYCLES cycles after the first high link_sync sample.
  - STABLE: link_stable = 1; the retry count is cleared on entry.
    - link_sync = 0 → link_down_latched set; link_loss_cnt increments and saturates at 255; next state per the optional feature. link_stable drops on the following cycle.
  - FAIL: retry_exhausted = 1, ch_reset_out = 0. Held until a ch_retry_clr pulse, which moves the channel to CH_RST with retry count 0. ch_retry_clr is ignored in every other state.
- link_down_latched_clr in the same cycle as a new loss event: the set wins, latched = 1 and link_loss_cnt = 1.
- Counter widths use $clog2 of their parameter. All comparisons are exact; there is no wrap-around.

Optional Feature:
GTF_LINK_AUTO_RESET_EN
- Defined:
  - WAIT_LINK timeout at count == LINK_TIMEOUT-1 increments the retry count and goes to CH_RST.
  - Link loss in STABLE also increments the retry count and goes to CH_RST.
  - If the retry count after increment equals MAX_RETRIES, the channel goes to FAIL instead of CH_RST.
- Undefined:
  - No timeout; WAIT_LINK waits indefinitely.
  - Loss in STABLE goes to WAIT_LINK.
  - FAIL is unreachable and retry_exhausted is tied to 0.

Test Plan:
Parameters for all scenarios: NUM_CHANNEL=2, POWERUP_DELAY=10, RESET_CYCLES=4, STABLE_CYCLES=16, LINK_TIMEOUT=64, MAX_RETRIES=3.
1. Release reset, raise gtf_clk_wiz_locked at t0 → global_busy falls at t0+2+10+1 (±1); ch_reset_out falls after RESET_CYCLES.
2. link_status_in[0] high steadily → link_stable[0] = 1 exactly 2+16 cycles after the edge; channel 1 is unaffected.
3. link_status_in[0] glitches low for 1 cycle at qualify count 10 → requalification restarts; link_stable[0] is delayed by 16 cycles from the recovery.
4. Drop link from STABLE → link_down_latched[0] = 1 and link_loss_cnt[0] = 1. Apply 300 losses → count holds 255. A clear pulse in the same cycle as a loss → latched = 1, count = 1.
5. GTF_LINK_AUTO_RESET_EN defined, link held low → 3 CH_RST pulses 64+4 cycles apart, then retry_exhausted[0] = 1. A ch_retry_clr pulse → CH_RST, and retry_exhausted[0] clears.
6. Drop gtf_clk_wiz_locked while both channels are in STABLE → within 3 cycles both ch_reset_out = 1 and link_stable = 0; loss counters are unchanged.
